// File: rtl/mont_exp_ctrl.sv
// Left-to-right binary modular exponentiation controller driving an external
// Montgomery multiplier. Converts the base into the Montgomery domain, runs
// square/multiply over the exponent bits, and converts the result back out.
//
// state      | meaning
// IDLE       | waiting for start
// TOMONT_I/W | issue/wait xt = MontMul(x, r2); acc = r
// SCAN       | skip leading zero exponent bits, one bit per cycle
// SQ_I/W     | issue/wait acc = MontMul(acc, acc)
// MUL_I/W    | issue/wait acc = MontMul(acc, xt)
// NEXT       | step idx down or leave the loop at bit 0
// FROMMONT_I/W | issue/wait result = MontMul(acc, 1)
// DONE       | one-cycle done pulse
module mont_exp_ctrl #(
  parameter int N      = 512,
  parameter int E_BITS = 512,
  localparam int IW    = (E_BITS > 1) ? $clog2(E_BITS) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [N-1:0]      in_x,
  input  logic [E_BITS-1:0] in_e,
  input  logic [N-1:0]      in_m,
  input  logic [N-1:0]      in_r,
  input  logic [N-1:0]      in_r2,
  output logic [N-1:0]      result,
  output logic              done,
  output logic              busy,
  output logic              mm_start,
  output logic [N-1:0]      mm_a,
  output logic [N-1:0]      mm_b,
  output logic [N-1:0]      mm_m,
  input  logic [N-1:0]      mm_result,
  input  logic              mm_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_TOMONT_I, S_TOMONT_W, S_SCAN, S_SQ_I, S_SQ_W,
    S_MUL_I, S_MUL_W, S_NEXT, S_FROMMONT_I, S_FROMMONT_W, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      x_q, x_d, m_q, m_d, r_q, r_d, r2_q, r2_d;
  logic [E_BITS-1:0] e_q, e_d;
  logic [N-1:0]      xt_q, xt_d, acc_q, acc_d, result_q, result_d;
  logic [N-1:0]      mm_a_q, mm_a_d, mm_b_q, mm_b_d;
  logic              mm_start_q, mm_start_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              op_done;

  // A done pulse coinciding with our own start pulse cannot belong to this op.
  assign op_done = mm_done && !mm_start_q;

  // Next-state, operand selection and datapath capture.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    e_d        = e_q;
    m_d        = m_q;
    r_d        = r_q;
    r2_d       = r2_q;
    xt_d       = xt_q;
    acc_d      = acc_q;
    result_d   = result_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    mm_start_d = 1'b0;
    idx_d      = idx_q;
    case (state_q)
      S_IDLE: if (start) begin
        x_d     = in_x;
        e_d     = in_e;
        m_d     = in_m;
        r_d     = in_r;
        r2_d    = in_r2;
        idx_d   = IW'(E_BITS - 1);
        state_d = S_TOMONT_I;
      end
      S_TOMONT_I: begin
        mm_a_d     = x_q;
        mm_b_d     = r2_q;
        mm_start_d = 1'b1;
        acc_d      = r_q;
        state_d    = S_TOMONT_W;
      end
      S_TOMONT_W: if (op_done) begin
        xt_d    = mm_result;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (e_q[idx_q])       state_d = S_SQ_I;
        else if (idx_q == '0) state_d = S_FROMMONT_I;
        else                  idx_d   = idx_q - IW'(1);
      end
      S_SQ_I: begin
        mm_a_d     = acc_q;
        mm_b_d     = acc_q;
        mm_start_d = 1'b1;
        state_d    = S_SQ_W;
      end
      S_SQ_W: if (op_done) begin
        acc_d   = mm_result;
        state_d = e_q[idx_q] ? S_MUL_I : S_NEXT;
      end
      S_MUL_I: begin
        mm_a_d     = acc_q;
        mm_b_d     = xt_q;
        mm_start_d = 1'b1;
        state_d    = S_MUL_W;
      end
      S_MUL_W: if (op_done) begin
        acc_d   = mm_result;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == '0) state_d = S_FROMMONT_I;
        else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_SQ_I;
        end
      end
      S_FROMMONT_I: begin
        mm_a_d     = acc_q;
        mm_b_d     = N'(1);
        mm_start_d = 1'b1;
        state_d    = S_FROMMONT_W;
      end
      S_FROMMONT_W: if (op_done) begin
        result_d = mm_result;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      e_q        <= '0;
      m_q        <= '0;
      r_q        <= '0;
      r2_q       <= '0;
      xt_q       <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_start_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      e_q        <= e_d;
      m_q        <= m_d;
      r_q        <= r_d;
      r2_q       <= r2_d;
      xt_q       <= xt_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_start_q <= mm_start_d;
      idx_q      <= idx_d;
    end
  end

  assign result   = result_q;
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl with N=8, E_BITS=8, M=13 (R mod M = 9, R^2 mod M = 3,
// R^-1 mod M = 3). A behavioural multiplier answers after a programmable latency.
module tb_mont_exp_ctrl;

  localparam int N = 8;
  localparam int EB = 8;
  localparam int M = 13;
  localparam int RINV = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  in_x = '0;
  logic [EB-1:0] in_e = '0;
  logic [N-1:0]  in_m = 8'd13;
  logic [N-1:0]  in_r = 8'd9;
  logic [N-1:0]  in_r2 = 8'd3;
  logic [N-1:0]  result;
  logic          done, busy, mm_start;
  logic [N-1:0]  mm_a, mm_b, mm_m;
  logic [N-1:0]  mm_result = '0;
  logic          mm_done = 1'b0;

  int total = 0;
  int bad = 0;
  int lat = 3;
  int pulses = 0;
  int ops_done = 0;
  int inj_req = 0;
  int inj_ack = 0;

  mont_exp_ctrl #(.N(N), .E_BITS(EB)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_pow(input int x, input int e);
    int r = 1 % M;
    for (int i = 0; i < e; i++) r = (r * x) % M;
    return r;
  endfunction

  function automatic int ref_ops(input int e);
    int msb = -1;
    int pop = 0;
    for (int i = 0; i < EB; i++) if ((e >> i) & 1) begin msb = i; pop++; end
    return 2 + (msb + 1) + pop;
  endfunction

  // Behavioural Montgomery multiplier: answers A*B*R^-1 mod M after lat cycles,
  // and flags any operand movement while a multiply is outstanding.
  initial begin : mm_model
    bit pend = 0;
    int cnt = 0;
    logic [N-1:0] sa = '0, sb = '0, sm = '0;
    int res = 0;
    forever begin
      @(posedge clk); #1;
      mm_done = 1'b0;
      if (!resetn) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("operand_stable", {8'd0, mm_a, mm_b, mm_m}, {8'd0, sa, sb, sm});
          if (cnt <= 1) begin
            mm_done = 1'b1;
            mm_result = N'(res);
            pend = 0;
            ops_done++;
          end else cnt--;
        end else if (inj_req != inj_ack) begin
          mm_done = 1'b1;
          mm_result = 8'hAA;
          inj_ack++;
        end
        if (mm_start === 1'b1) begin
          pend = 1;
          cnt = lat;
          sa = mm_a; sb = mm_b; sm = mm_m;
          res = (int'(mm_a) * int'(mm_b) * RINV) % M;
          pulses++;
        end
      end
    end
  end

  task automatic kick(input int x, input int e);
    pulses = 0;
    ops_done = 0;
    in_x = N'(x);
    in_e = EB'(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_job(input string tag, input int exp_res, input int exp_ops);
    int n = 0;
    while (done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_pulses"}, pulses, exp_ops);
    chk({tag, "_busy_in_done"}, busy, 1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_result_held"}, result, exp_res);
  endtask

  task automatic run_job(input string tag, input int x, input int e, input int l);
    lat = l;
    kick(x, e);
    finish_job(tag, ref_pow(x, e), ref_ops(e));
  endtask

  initial begin : main
    int n;
    int cnt_done;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_b", mm_b, 0);
    chk("rst_mm_m", mm_m, 0);
    chk("rst_flags", {done, busy, mm_start}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // T1 / T2 / T3 directed cases
    run_job("t1", 2, 5, 3);
    run_job("t2_e0", 7, 0, 2);
    run_job("t2_x0", 0, 3, 2);
    run_job("t2_e1", 2, 1, 2);
    run_job("t3_all_ones", 12, 255, 1);

    // T4: long latency with a stray mm_done during SCAN
    lat = 100;
    kick(5, 3);
    n = 0;
    while (ops_done < 1 && n < 500) begin @(negedge clk); n++; end
    chk("t4_first_op", ops_done, 1);
    inj_req++;
    finish_job("t4", ref_pow(5, 3), ref_ops(3));
    chk("t4_inject_consumed", inj_ack, inj_req);

    // T5: start while busy is ignored
    lat = 3;
    kick(2, 5);
    repeat (5) @(negedge clk);
    in_x = 8'd7; in_e = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_job("t5_restart", 6, 7);
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (done === 1'b1) cnt_done++; end
    chk("t5_single_done", cnt_done, 0);

    // T5: reset in the middle of a WAIT
    lat = 20;
    kick(2, 5);
    n = 0;
    while (pulses < 3 && n < 500) begin @(negedge clk); n++; end
    chk("t5_reached_wait", pulses, 3);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_result", result, 0);
    chk("abort_mm_a", mm_a, 0);
    chk("abort_mm_b", mm_b, 0);
    chk("abort_mm_m", mm_m, 0);
    chk("abort_flags", {done, busy, mm_start}, 0);
    resetn = 1'b1;
    @(negedge clk);
    run_job("t5_after_reset", 2, 5, 3);

    // T6: back-to-back jobs, result held across the second run
    run_job("t6_a", 3, 4, 2);
    lat = 2;
    kick(3, 4);
    chk("t6_hold_early", result, 3);
    repeat (10) @(negedge clk);
    chk("t6_hold_mid", result, 3);
    finish_job("t6_b", 3, ref_ops(4));

    // Randomised jobs against the arithmetic reference
    for (int i = 0; i < 8; i++) begin
      int rx, re, rl;
      rx = int'($urandom_range(0, M - 1));
      re = int'($urandom_range(0, 255));
      rl = int'($urandom_range(1, 6));
      run_job("rand", rx, re, rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
